// File: rtl/game_status_tracker_pkg.sv
// -----------------------------------------------------------------------------
// game_status_tracker_pkg
// Shared constants and types for the game status tracker:
//   - default game parameters (lives, score prescale, blink half period)
//   - output field widths and the saturating BCD score limit
//   - tracker FSM state encoding
// -----------------------------------------------------------------------------
package game_status_tracker_pkg;

  // Default game parameters (overridable on the top module).
  localparam int DEF_MAX_LIFE          = 4;
  localparam int DEF_TICKS_PER_POINT   = 100;
  localparam int DEF_BLINK_HALF_PERIOD = 25;

  // Output field widths.
  localparam int LIFE_LENGTH  = 3;
  localparam int SCORE_LENGTH = 16;

  // Score saturates here: four BCD nines.
  localparam logic [SCORE_LENGTH-1:0] SCORE_MAX_BCD = 16'h9999;

  // Tracker FSM states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_FINISHED = 2'd2
  } tracker_state_t;

  // Counter width for a modulus-n counter; never narrower than one bit so a
  // modulus of 1 still yields a legal vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_status_tracker_bcd_score_counter.sv
// -----------------------------------------------------------------------------
// game_status_tracker_bcd_score_counter
// Four-digit BCD up-counter with digit-wise ripple carry, saturating at 9999.
// Ports:
//   CLK    in  1   clock, rising edge
//   RESET  in  1   asynchronous active-high reset, VALUE -> 0
//   CLEAR  in  1   synchronous clear (takes priority over INC)
//   INC    in  1   add one point on this edge
//   VALUE  out 16  registered BCD value, [15:12] = thousands
// -----------------------------------------------------------------------------
module game_status_tracker_bcd_score_counter
  import game_status_tracker_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    CLEAR,
  input  logic                    INC,
  output logic [SCORE_LENGTH-1:0] VALUE
);

  logic [SCORE_LENGTH-1:0] r_value;
  logic [SCORE_LENGTH-1:0] w_next;
  logic                    w_carry;

  // Ripple a carry from the units digit upward: every digit that was 9 wraps
  // to 0 and passes the carry on; the first digit below 9 absorbs it.
  always_comb begin
    w_next  = r_value;
    w_carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (w_carry) begin
        if (r_value[d*4 +: 4] == 4'd9) begin
          w_next[d*4 +: 4] = 4'd0;
        end else begin
          w_next[d*4 +: 4] = r_value[d*4 +: 4] + 4'd1;
          w_carry          = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_value <= '0;
    end else if (CLEAR) begin
      r_value <= '0;
    end else if (INC && (r_value != SCORE_MAX_BCD)) begin
      r_value <= w_next;
    end
  end

  assign VALUE = r_value;

endmodule

// File: rtl/game_status_tracker.sv
// -----------------------------------------------------------------------------
// game_status_tracker
// Consumes the referee outputs and keeps the player-facing game status:
// lives left, survival score (BCD, one point per TICKS_PER_POINT cycles),
// session high score, new-record flag and the invincibility blink.
//
// Handshake: there is no valid/ready flow here. Every input is a level sampled
// on the CLK rising edge; HURT/RECOVER are turned into one event per rising
// edge, START is a level in IDLE and a rising edge in FINISHED. Every output is
// registered and changes one rising edge after the input that caused it.
//
// Ports:
//   CLK            in  1   game clock, rising edge
//   RESET          in  1   asynchronous active-high reset
//   START          in  1   game start request (level)
//   HURT           in  1   referee hurt pulse
//   RECOVER        in  1   referee recover pulse
//   INVINCIBLE     in  1   referee invincibility level
//   OVER           in  1   referee game-over level
//   LIFE           out 3   lives remaining, 0..MAX_LIFE
//   SCORE_BCD      out 16  current score, 4 BCD digits
//   HIGH_SCORE_BCD out 16  best score since reset, 4 BCD digits
//   SQUARE_VISIBLE out 1   player square drawn when 1
//   NEW_RECORD     out 1   last finished game set a new high score
//   DBG_STATE      out 2   tracker FSM state (debug observation)
// -----------------------------------------------------------------------------
module game_status_tracker
  import game_status_tracker_pkg::*;
#(
  parameter int MAX_LIFE          = DEF_MAX_LIFE,
  parameter int TICKS_PER_POINT   = DEF_TICKS_PER_POINT,
  parameter int BLINK_HALF_PERIOD = DEF_BLINK_HALF_PERIOD
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    START,
  input  logic                    HURT,
  input  logic                    RECOVER,
  input  logic                    INVINCIBLE,
  input  logic                    OVER,
  output logic [LIFE_LENGTH-1:0]  LIFE,
  output logic [SCORE_LENGTH-1:0] SCORE_BCD,
  output logic [SCORE_LENGTH-1:0] HIGH_SCORE_BCD,
  output logic                    SQUARE_VISIBLE,
  output logic                    NEW_RECORD,
  output logic [1:0]              DBG_STATE
);

  localparam int PRESC_W = cnt_width(TICKS_PER_POINT);
  localparam int BLINK_W = cnt_width(BLINK_HALF_PERIOD);

  localparam logic [PRESC_W-1:0]     PRESC_LAST = PRESC_W'(TICKS_PER_POINT - 1);
  localparam logic [BLINK_W-1:0]     BLINK_LAST = BLINK_W'(BLINK_HALF_PERIOD - 1);
  localparam logic [LIFE_LENGTH-1:0] LIFE_FULL  = LIFE_LENGTH'(MAX_LIFE);

  tracker_state_t          r_state;
  logic [LIFE_LENGTH-1:0]  r_life;
  logic [SCORE_LENGTH-1:0] r_high;
  logic                    r_new_record;
  logic [PRESC_W-1:0]      r_presc;
  logic [BLINK_W-1:0]      r_blink_cnt;
  logic                    r_visible;
  logic                    r_hurt_q;
  logic                    r_rec_q;
  logic                    r_start_q;

  logic                    w_hurt_evt;
  logic                    w_rec_evt;
  logic                    w_start_rise;
  logic                    w_game_start;
  logic                    w_tick;
  logic [SCORE_LENGTH-1:0] w_score;

  assign w_hurt_evt   = HURT    & ~r_hurt_q;
  assign w_rec_evt    = RECOVER & ~r_rec_q;
  assign w_start_rise = START   & ~r_start_q;

  // A new game begins on START level from IDLE, but only on a fresh START
  // edge from FINISHED so a START held through game-over does not restart.
  assign w_game_start = ((r_state == ST_IDLE) && START) ||
                        ((r_state == ST_FINISHED) && w_start_rise);

  // OVER freezes the score in its cycle, so it masks the point tick.
  assign w_tick = (r_state == ST_RUNNING) && !OVER && (r_presc == PRESC_LAST);

  game_status_tracker_bcd_score_counter u_score (
    .CLK   (CLK),
    .RESET (RESET),
    .CLEAR (w_game_start),
    .INC   (w_tick),
    .VALUE (w_score)
  );

  // Game FSM together with prescaler, lives and high score.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= ST_IDLE;
      r_life       <= LIFE_FULL;
      r_high       <= '0;
      r_new_record <= 1'b0;
      r_presc      <= '0;
      r_hurt_q     <= 1'b0;
      r_rec_q      <= 1'b0;
      r_start_q    <= 1'b0;
    end else begin
      r_hurt_q  <= HURT;
      r_rec_q   <= RECOVER;
      r_start_q <= START;
      case (r_state)
        ST_IDLE: begin
          r_presc <= '0;
          if (START) begin
            r_state      <= ST_RUNNING;
            r_life       <= LIFE_FULL;
            r_new_record <= 1'b0;
          end
        end
        ST_RUNNING: begin
          if (OVER) begin
            r_state <= ST_FINISHED;
            r_life  <= '0;
            // Packed BCD orders the same as binary, so a plain compare works.
            if (w_score > r_high) begin
              r_high       <= w_score;
              r_new_record <= 1'b1;
            end
          end else begin
            r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
            // Hurt wins over a coincident recover.
            if (w_hurt_evt) begin
              if (r_life != '0) r_life <= r_life - LIFE_LENGTH'(1);
            end else if (w_rec_evt) begin
              if (r_life != LIFE_FULL) r_life <= r_life + LIFE_LENGTH'(1);
            end
          end
        end
        ST_FINISHED: begin
          if (w_start_rise) begin
            r_state      <= ST_RUNNING;
            r_life       <= LIFE_FULL;
            r_new_record <= 1'b0;
            r_presc      <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Invincibility blink: visible for one half period, hidden for the next,
  // starting visible. Anything other than invincible-while-running forces the
  // square visible and restarts the phase.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_visible   <= 1'b1;
      r_blink_cnt <= '0;
    end else if ((r_state == ST_RUNNING) && INVINCIBLE) begin
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_visible   <= ~r_visible;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end
    end else begin
      r_visible   <= 1'b1;
      r_blink_cnt <= '0;
    end
  end

  assign LIFE           = r_life;
  assign SCORE_BCD      = w_score;
  assign HIGH_SCORE_BCD = r_high;
  assign SQUARE_VISIBLE = r_visible;
  assign NEW_RECORD     = r_new_record;
  assign DBG_STATE      = r_state;

endmodule

// File: tb/tb_game_status_tracker.sv
// -----------------------------------------------------------------------------
// tb_game_status_tracker
// Drives the tracker with directed referee sequences. A game-level model
// (lives, cycles survived, best score) predicts every output each cycle, and
// literal checkpoints pin the model at the interesting moments. A second
// instance with one cycle per point reaches score saturation quickly.
// -----------------------------------------------------------------------------
module tb_game_status_tracker;

  localparam int T  = 100;
  localparam int B  = 25;
  localparam int ML = 4;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic START = 1'b0, HURT = 1'b0, RECOVER = 1'b0, INVINCIBLE = 1'b0, OVER = 1'b0;
  logic rst_f = 1'b1, start_f = 1'b0;

  always #5 CLK = ~CLK;

  logic [2:0]  life, life_f;
  logic [15:0] score, high, score_f, high_f;
  logic        vis, nr, vis_f, nr_f;
  logic [1:0]  dbg, dbg_f;

  game_status_tracker dut (
    .CLK(CLK), .RESET(RESET), .START(START), .HURT(HURT), .RECOVER(RECOVER),
    .INVINCIBLE(INVINCIBLE), .OVER(OVER), .LIFE(life), .SCORE_BCD(score),
    .HIGH_SCORE_BCD(high), .SQUARE_VISIBLE(vis), .NEW_RECORD(nr), .DBG_STATE(dbg)
  );

  game_status_tracker #(.TICKS_PER_POINT(1)) dut_f (
    .CLK(CLK), .RESET(rst_f), .START(start_f), .HURT(1'b0), .RECOVER(1'b0),
    .INVINCIBLE(1'b0), .OVER(1'b0), .LIFE(life_f), .SCORE_BCD(score_f),
    .HIGH_SCORE_BCD(high_f), .SQUARE_VISIBLE(vis_f), .NEW_RECORD(nr_f), .DBG_STATE(dbg_f)
  );

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [15:0] exp_q[$];
  bit fast_done = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  // ---------------- game model ----------------
  localparam int G_IDLE = 0, G_PLAY = 1, G_DONE = 2;
  int m_phase, m_life, m_cycles, m_best, m_inv_run;
  bit m_record, p_hurt, p_rec, p_start;
  int f_points;
  bit f_playing;

  function automatic int points(input int cycles, input int per_point);
    int p;
    p = cycles / per_point;
    return (p > 9999) ? 9999 : p;
  endfunction

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_phase = G_IDLE; m_life = ML; m_cycles = 0; m_best = 0;
      m_record = 0; m_inv_run = 0; p_hurt = 0; p_rec = 0; p_start = 0;
    end else begin
      m_inv_run = (m_phase == G_PLAY && INVINCIBLE) ? m_inv_run + 1 : 0;
      if (m_phase == G_IDLE) begin
        if (START) begin m_phase = G_PLAY; m_life = ML; m_cycles = 0; m_record = 0; end
      end else if (m_phase == G_PLAY) begin
        if (OVER) begin
          m_phase = G_DONE;
          m_life = 0;
          if (points(m_cycles, T) > m_best) begin
            m_best = points(m_cycles, T);
            m_record = 1;
          end
        end else begin
          m_cycles++;
          if (HURT && !p_hurt) m_life = (m_life > 0) ? m_life - 1 : 0;
          else if (RECOVER && !p_rec) m_life = (m_life < ML) ? m_life + 1 : ML;
        end
      end else if (START && !p_start) begin
        m_phase = G_PLAY; m_life = ML; m_cycles = 0; m_record = 0;
      end
      p_hurt = HURT; p_rec = RECOVER; p_start = START;
    end
  end

  // Fast instance: one point per cycle once playing.
  always @(posedge CLK or posedge rst_f) begin
    if (rst_f) begin
      f_playing = 0; f_points = 0;
    end else if (f_playing) begin
      f_points++;
    end else if (start_f) begin
      f_playing = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    check("life", {13'd0, life}, 16'(m_life));
    check("score", score, to_bcd(points(m_cycles, T)));
    check("high", high, to_bcd(m_best));
    check("new_record", {15'd0, nr}, {15'd0, m_record});
    check("visible", {15'd0, vis}, {15'd0, ((m_inv_run / B) % 2) == 0});
    check("fast_score", score_f, to_bcd(points(f_points, 1)));
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_hurt();
    @(negedge CLK); HURT = 1'b1;
    @(negedge CLK); HURT = 1'b0;
  endtask

  task automatic pulse_rec();
    @(negedge CLK); RECOVER = 1'b1;
    @(negedge CLK); RECOVER = 1'b0;
  endtask

  // ---------------- fast instance: saturation ----------------
  initial begin
    repeat (2) @(negedge CLK);
    rst_f = 1'b0; start_f = 1'b1;
    repeat (10199) @(negedge CLK);
    check("fast_saturated", score_f, 16'h9999);
    check("fast_life", {13'd0, life_f}, 16'd4);
    check("fast_high", high_f, 16'h0000);
    check("fast_visible", {15'd0, vis_f}, 16'd1);
    check("fast_record", {15'd0, nr_f}, 16'd0);
    check("fast_state", {14'd0, dbg_f}, 16'd1);
    fast_done = 1;
  end

  // ---------------- main sequence ----------------
  int ones [4];
  logic v_after;

  initial begin
    repeat (2) @(negedge CLK);
    check("reset_life", {13'd0, life}, 16'd4);
    check("reset_score", score, 16'h0000);
    check("reset_visible", {15'd0, vis}, 16'd1);
    check("reset_state", {14'd0, dbg}, 16'd0);

    // Score counting with no events.
    RESET = 1'b0; START = 1'b1;
    repeat (350) @(negedge CLK);
    check("t1_score", score, 16'h0003);
    check("t1_life", {13'd0, life}, 16'd4);
    check("t1_visible", {15'd0, vis}, 16'd1);

    // BCD carry across two digits.
    repeat (9649) @(negedge CLK);
    check("t2_before_carry", score, 16'h0099);
    repeat (2) @(negedge CLK);
    check("t2_after_carry", score, 16'h0100);

    // Edge-detected lives.
    HURT = 1'b1;
    repeat (3) @(negedge CLK);
    HURT = 1'b0;
    @(negedge CLK);
    check("t3_long_hurt", {13'd0, life}, 16'd3);
    HURT = 1'b1; RECOVER = 1'b1;
    @(negedge CLK);
    HURT = 1'b0; RECOVER = 1'b0;
    @(negedge CLK);
    check("t3_hurt_wins", {13'd0, life}, 16'd2);
    pulse_rec(); pulse_rec();
    check("t3_recovered", {13'd0, life}, 16'd4);
    pulse_rec();
    check("t3_recover_sat", {13'd0, life}, 16'd4);

    // Blink pattern over 100 invincible cycles.
    @(negedge CLK);
    INVINCIBLE = 1'b1;
    ones = '{0, 0, 0, 0};
    for (int i = 0; i < 100; i++) begin
      if (i > 0) @(negedge CLK);
      if (vis) ones[i / 25]++;
    end
    @(negedge CLK);
    INVINCIBLE = 1'b0;
    @(negedge CLK);
    v_after = vis;
    check("t4_phase0_visible", 16'(ones[0]), 16'd25);
    check("t4_phase1_hidden", 16'(ones[1]), 16'd0);
    check("t4_phase2_visible", 16'(ones[2]), 16'd25);
    check("t4_phase3_hidden", 16'(ones[3]), 16'd0);
    check("t4_after_fall", {15'd0, v_after}, 16'd1);

    // Async reset in the middle of a game, while hurt and hidden.
    pulse_hurt();
    @(negedge CLK);
    INVINCIBLE = 1'b1;
    repeat (30) @(negedge CLK);
    check("t6_hidden_before", {15'd0, vis}, 16'd0);
    #2 RESET = 1'b1;
    #1;
    check("t6_async_life", {13'd0, life}, 16'd4);
    check("t6_async_score", score, 16'h0000);
    check("t6_async_visible", {15'd0, vis}, 16'd1);
    check("t6_async_state", {14'd0, dbg}, 16'd0);
    START = 1'b0; INVINCIBLE = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    repeat (200) @(negedge CLK);
    check("t6_idle_score", score, 16'h0000);

    // Game 1 ends at 12 points.
    START = 1'b1;
    repeat (1251) @(negedge CLK);
    OVER = 1'b1;
    @(negedge CLK);
    check("t5_g1_score", score, 16'h0012);
    check("t5_g1_high", high, 16'h0012);
    check("t5_g1_record", {15'd0, nr}, 16'd1);
    check("t5_g1_life", {13'd0, life}, 16'd0);
    START = 1'b0; OVER = 1'b0;
    repeat (20) @(negedge CLK);
    check("t5_finished_hold", score, 16'h0012);

    // Game 2 ends at 8 points, lives run out on the way.
    START = 1'b1;
    for (int k = 0; k < 5; k++) pulse_hurt();
    check("t5_g2_life_floor", {13'd0, life}, 16'd0);
    repeat (841) @(negedge CLK);
    OVER = 1'b1;
    @(negedge CLK);
    check("t5_g2_score", score, 16'h0008);
    check("t5_g2_high", high, 16'h0012);
    check("t5_g2_record", {15'd0, nr}, 16'd0);
    OVER = 1'b0;
    repeat (5) @(negedge CLK);

    exp_q.push_back(16'd1);
    check("fast_instance_done", {15'd0, fast_done}, exp_q.pop_front());

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    tests_run++;
    tests_failed++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
